// File: rtl/tpu_pkg.sv
// Shared types for the TPU host sequencer: opcode encoding, sequencer states,
// and the fixed matrix geometry (8x8 split into two 4-element halves).
package tpu_pkg;

  localparam int TPU_DIM  = 8;
  localparam int TPU_HALF = 4;

  typedef enum logic [2:0] {
    OP_WRITE_A  = 3'd0,
    OP_WRITE_B  = 3'd1,
    OP_WRITE_C  = 3'd2,
    OP_MATMUL   = 3'd3,
    OP_READ_C   = 3'd4,
    OP_SYS_STEP = 3'd5,
    OP_NOP      = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    CLRC  = 3'd3,
    MUL   = 3'd4,
    READ  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/tpu_host_sequencer.sv
// Host-side sequencer: loads A/B rows, optionally clears C, runs matmul, reads C back.
// All TPU-side outputs and the result half-row are registered; results held until res_ready.
module tpu_host_sequencer
  import tpu_pkg::*;
#(
  parameter int BITS_AB       = 32,
  parameter int BITS_C        = 32,
  parameter int DIM           = 8,
  parameter int MATMUL_CYCLES = 3*DIM-2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic                   cmd_clr,
  output logic                   cmd_ready,
  output logic                   done,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [DIM*BITS_AB-1:0] op_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [BITS_C-1:0]      res_data [TPU_HALF],
  output logic [3:0]             res_row,
  output logic                   res_hl,
  output logic [2:0]             opcode,
  output logic [3:0]             idx,
  output logic                   hl,
  output logic [BITS_AB-1:0]     v_low  [TPU_HALF],
  output logic [BITS_AB-1:0]     v_high [TPU_HALF],
  input  logic [BITS_C-1:0]      data_out [TPU_HALF]
);

  localparam int              CYC_W    = $clog2(MATMUL_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MATMUL_CYCLES - 1);
  localparam logic [3:0]      ROW_LAST = 4'(TPU_DIM - 1);

  seq_state_t           state_q, state_d;
  logic [3:0]           row_q, row_d;
  logic                 half_q, half_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic                 clr_q, clr_d;
  logic                 rd_all_q, rd_all_d;

  opcode_t              opcode_q, opcode_d;
  logic [3:0]           idx_q, idx_d;
  logic                 hl_q, hl_d;
  logic [BITS_AB-1:0]   v_low_q  [TPU_HALF];
  logic [BITS_AB-1:0]   v_low_d  [TPU_HALF];
  logic [BITS_AB-1:0]   v_high_q [TPU_HALF];
  logic [BITS_AB-1:0]   v_high_d [TPU_HALF];

  logic                 res_valid_q, res_valid_d;
  logic [BITS_C-1:0]    res_data_q [TPU_HALF];
  logic [BITS_C-1:0]    res_data_d [TPU_HALF];
  logic [3:0]           res_row_q, res_row_d;
  logic                 res_hl_q, res_hl_d;
  logic                 done_q, done_d;

  logic                 res_accept;
  logic                 rd_issue_ok;

  assign res_accept  = res_valid_q && res_ready;
  // A freshly accepted result frees the slot in the same cycle, giving 2 cycles per half-row.
  assign rd_issue_ok = (!res_valid_q || res_ready) && (opcode_q != OP_READ_C) && !rd_all_q;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    half_d      = half_q;
    cyc_d       = cyc_q;
    clr_d       = clr_q;
    rd_all_d    = rd_all_q;
    opcode_d    = OP_NOP;
    idx_d       = idx_q;
    hl_d        = hl_q;
    v_low_d     = v_low_q;
    v_high_d    = v_high_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_row_d   = res_row_q;
    res_hl_d    = res_hl_q;
    done_d      = 1'b0;

    if (res_accept) begin
      res_valid_d = 1'b0;
    end
    // data_out is combinational from the registered readC, so capture it on the closing edge.
    if (opcode_q == OP_READ_C) begin
      res_valid_d = 1'b1;
      res_data_d  = data_out;
      res_row_d   = idx_q;
      res_hl_d    = hl_q;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          clr_d   = cmd_clr;
          row_d   = '0;
          half_d  = 1'b0;
          state_d = LOADA;
        end
      end

      LOADA, LOADB: begin
        if (op_valid) begin
          opcode_d = (state_q == LOADA) ? OP_WRITE_A : OP_WRITE_B;
          idx_d    = row_q;
          hl_d     = 1'b0;
          for (int c = 0; c < TPU_HALF; c++) begin
            v_low_d[c]  = op_data[c*BITS_AB +: BITS_AB];
            v_high_d[c] = op_data[(c+TPU_HALF)*BITS_AB +: BITS_AB];
          end
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (state_q == LOADA) begin
              state_d = LOADB;
            end else begin
              cyc_d   = '0;
              state_d = clr_q ? CLRC : MUL;
            end
          end else begin
            row_d = row_q + 4'd1;
          end
        end
      end

      CLRC: begin
        opcode_d = OP_WRITE_C;
        idx_d    = row_q;
        hl_d     = half_q;
        for (int c = 0; c < TPU_HALF; c++) begin
          v_low_d[c]  = '0;
          v_high_d[c] = '0;
        end
        half_d = ~half_q;
        if (half_q) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            cyc_d   = '0;
            state_d = MUL;
          end else begin
            row_d = row_q + 4'd1;
          end
        end
      end

      MUL: begin
        opcode_d = OP_MATMUL;
        idx_d    = '0;
        hl_d     = 1'b0;
        for (int c = 0; c < TPU_HALF; c++) begin
          v_low_d[c]  = '0;
          v_high_d[c] = '0;
        end
        if (cyc_q == CYC_LAST) begin
          cyc_d    = '0;
          row_d    = '0;
          half_d   = 1'b0;
          rd_all_d = 1'b0;
          state_d  = READ;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      READ: begin
        if (rd_issue_ok) begin
          opcode_d = OP_READ_C;
          idx_d    = row_q;
          hl_d     = half_q;
          for (int c = 0; c < TPU_HALF; c++) begin
            v_low_d[c]  = '0;
            v_high_d[c] = '0;
          end
          half_d = ~half_q;
          if (half_q) begin
            if (row_q == ROW_LAST) begin
              row_d    = '0;
              rd_all_d = 1'b1;
            end else begin
              row_d = row_q + 4'd1;
            end
          end
        end
        if (res_accept && res_row_q == ROW_LAST && res_hl_q) begin
          done_d   = 1'b1;
          rd_all_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      half_q      <= 1'b0;
      cyc_q       <= '0;
      clr_q       <= 1'b0;
      rd_all_q    <= 1'b0;
      opcode_q    <= OP_NOP;
      idx_q       <= '0;
      hl_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_row_q   <= '0;
      res_hl_q    <= 1'b0;
      done_q      <= 1'b0;
      for (int c = 0; c < TPU_HALF; c++) begin
        v_low_q[c]    <= '0;
        v_high_q[c]   <= '0;
        res_data_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      half_q      <= half_d;
      cyc_q       <= cyc_d;
      clr_q       <= clr_d;
      rd_all_q    <= rd_all_d;
      opcode_q    <= opcode_d;
      idx_q       <= idx_d;
      hl_q        <= hl_d;
      res_valid_q <= res_valid_d;
      res_row_q   <= res_row_d;
      res_hl_q    <= res_hl_d;
      done_q      <= done_d;
      v_low_q     <= v_low_d;
      v_high_q    <= v_high_d;
      res_data_q  <= res_data_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign op_ready  = (state_q == LOADA) || (state_q == LOADB);
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_row   = res_row_q;
  assign res_hl    = res_hl_q;
  assign opcode    = opcode_q;
  assign idx       = idx_q;
  assign hl        = hl_q;
  assign v_low     = v_low_q;
  assign v_high    = v_high_q;

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Bench for tpu_host_sequencer: TPU read model on data_out, expected opcode stream and
// result order built from the command description, compared against what the DUT issues.
module tb_tpu_host_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_clr, cmd_ready, done;
  logic         op_valid, op_ready;
  logic [255:0] op_data;
  logic         res_valid, res_ready;
  logic [31:0]  res_data [4];
  logic [3:0]   res_row;
  logic         res_hl;
  logic [2:0]   opcode;
  logic [3:0]   idx;
  logic         hl;
  logic [31:0]  v_low  [4];
  logic [31:0]  v_high [4];
  logic [31:0]  data_out [4];

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   op;
    logic [3:0]   idx;
    logic         hl;
    logic [255:0] v;
  } top_t;

  top_t         obs_ops[$];
  top_t         exp_ops[$];
  int           obs_cyc[$];
  logic [132:0] obs_res[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  logic [15:0]  salt = 16'h0;

  tpu_host_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_clr(cmd_clr), .cmd_ready(cmd_ready), .done(done),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_hl(res_hl),
    .opcode(opcode), .idx(idx), .hl(hl), .v_low(v_low), .v_high(v_high),
    .data_out(data_out)
  );

  function automatic logic [31:0] tpu_word(input logic [15:0] s, input logic [3:0] r,
                                           input logic h, input int k);
    logic [1:0] kk;
    kk = k[1:0];
    return {s, 4'h0, r, 3'b000, h, 2'b00, kk};
  endfunction

  // TPU read port: combinational from opcode/idx/hl, garbage unless readC.
  always_comb begin
    for (int k = 0; k < 4; k++)
      data_out[k] = (opcode == 3'd4) ? tpu_word(salt, idx, hl, k) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [287:0] o, input logic [287:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int count_op(input logic [2:0] o);
    int n = 0;
    foreach (obs_ops[i]) if (obs_ops[i].op == o) n++;
    return n;
  endfunction

  task automatic tick(output bit beat);
    bit acc, opr;
    top_t t;
    logic [132:0] r;
    beat = op_valid && op_ready;
    opr  = op_ready;
    acc  = res_valid && res_ready;
    if (acc) begin
      r[132:129] = res_row;
      r[128]     = res_hl;
      for (int k = 0; k < 4; k++) r[k*32 +: 32] = res_data[k];
      obs_res.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
    if (opcode != 3'd7) begin
      t.op  = opcode;
      t.idx = idx;
      t.hl  = (opcode == 3'd2 || opcode == 3'd4) ? hl : 1'b0;
      t.v   = '0;
      if (opcode != 3'd4)
        for (int c = 0; c < 4; c++) begin
          t.v[c*32 +: 32]     = v_low[c];
          t.v[(c+4)*32 +: 32] = v_high[c];
        end
      obs_ops.push_back(t);
      obs_cyc.push_back(cyc);
    end
    if (beat) chk("beat_write", 288'(opcode == 3'd0 || opcode == 3'd1), 288'(1));
    else if (opr) chk("gap_nop", 288'(opcode), 288'(7));
  endtask

  // dmode 0: directed A/B values; vmode 0/1/2: valid always/toggle/random;
  // rmode 0/1/2: ready always/random/10-cycle stall; abort_mul>0: reset after that many matmuls.
  task automatic run_cmd(input bit clr, input int dmode, input int vmode,
                         input int rmode, input int abort_mul);
    logic [31:0]  mat [16][8];
    top_t         e;
    int           feed = 0, n = 0, st = 0, left = 0, gaps = 0, first_rd, nres;
    bit           beat, tog = 1'b0, fin = 1'b0;
    logic [127:0] snap, cur;
    logic [132:0] er;

    salt = 16'($urandom);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++)
        mat[r][c] = (dmode == 0) ? ((r < 8) ? 32'(r*8 + c) : 32'(100 + (r-8)*8 + c))
                                 : $urandom;
    exp_ops.delete(); obs_ops.delete(); obs_cyc.delete(); obs_res.delete();
    done_cnt = 0;

    for (int r = 0; r < 16; r++) begin
      e.op = (r < 8) ? 3'd0 : 3'd1; e.idx = 4'(r % 8); e.hl = 1'b0; e.v = '0;
      for (int c = 0; c < 8; c++) e.v[c*32 +: 32] = mat[r][c];
      exp_ops.push_back(e);
    end
    if (clr)
      for (int r = 0; r < 8; r++)
        for (int h = 0; h < 2; h++) begin
          e.op = 3'd2; e.idx = 4'(r); e.hl = 1'(h); e.v = '0;
          exp_ops.push_back(e);
        end
    for (int m = 0; m < 22; m++) begin
      e.op = 3'd3; e.idx = 4'd0; e.hl = 1'b0; e.v = '0;
      exp_ops.push_back(e);
    end
    for (int r = 0; r < 8; r++)
      for (int h = 0; h < 2; h++) begin
        e.op = 3'd4; e.idx = 4'(r); e.hl = 1'(h); e.v = '0;
        exp_ops.push_back(e);
      end

    cmd_valid = 1'b1; cmd_clr = clr; op_valid = 1'b0; res_ready = 1'b1;
    tick(beat);
    chk("cmd_taken", 288'(op_ready), 288'(1));

    while (!fin && n < 3000) begin
      cmd_valid = 1'($urandom % 2);
      cmd_clr   = 1'($urandom % 2);
      tog = ~tog;
      if (feed < 16) begin
        op_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom % 2);
        for (int c = 0; c < 8; c++) op_data[c*32 +: 32] = mat[feed][c];
      end else begin
        op_valid = 1'($urandom % 2);
        for (int c = 0; c < 8; c++) op_data[c*32 +: 32] = $urandom;
      end
      case (rmode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom % 2);
        default: begin
          if (st == 0 && res_valid) begin
            st = 1; left = 10;
            for (int k = 0; k < 4; k++) snap[k*32 +: 32] = res_data[k];
          end
          res_ready = (st != 1);
        end
      endcase
      tick(beat);
      n++;
      if (beat) feed++;
      if (st == 1) begin
        for (int k = 0; k < 4; k++) cur[k*32 +: 32] = res_data[k];
        chk("stall_valid", 288'(res_valid), 288'(1));
        chk("stall_data", 288'(cur), 288'(snap));
        chk("stall_one_readc", 288'(count_op(3'd4)), 288'(1));
        left--;
        if (left == 0) st = 2;
      end
      if (abort_mul > 0 && count_op(3'd3) == abort_mul) begin
        rst = 1'b1; cmd_valid = 1'b0; op_valid = 1'b0;
        #1;
        chk("abort_async_nop", 288'(opcode), 288'(7));
        @(posedge clk);
        #1;
        chk("abort_edge_nop", 288'(opcode), 288'(7));
        chk("abort_cmd_ready", 288'(cmd_ready), 288'(1));
        chk("abort_op_ready", 288'(op_ready), 288'(0));
        chk("abort_res_valid", 288'(res_valid), 288'(0));
        rst = 1'b0;
        return;
      end
      if (done_cnt > 0) fin = 1'b1;
    end
    chk("cmd_finished", 288'(fin), 288'(1));

    cmd_valid = 1'b0; op_valid = 1'b0; res_ready = 1'b1;
    repeat (3) tick(beat);
    chk("done_once", 288'(done_cnt), 288'(1));
    chk("end_cmd_ready", 288'(cmd_ready), 288'(1));
    chk("end_op_ready", 288'(op_ready), 288'(0));
    chk("end_res_valid", 288'(res_valid), 288'(0));

    chk("op_count", 288'(obs_ops.size()), 288'(exp_ops.size()));
    for (int i = 0; i < obs_ops.size() && i < exp_ops.size(); i++)
      chk($sformatf("op%0d", i), 288'(obs_ops[i]), 288'(exp_ops[i]));

    // From writeB row 7 through the first readC the opcode stream has no bubbles.
    first_rd = 16 + (clr ? 16 : 0) + 22;
    for (int i = 15; i < first_rd && i + 1 < obs_cyc.size(); i++)
      if (obs_cyc[i+1] - obs_cyc[i] != 1) gaps++;
    chk("burst_gaps", 288'(gaps), 288'(0));
    if (rmode == 0) begin
      gaps = 0;
      for (int i = first_rd; i + 1 < obs_cyc.size(); i++)
        if (obs_cyc[i+1] - obs_cyc[i] != 2) gaps++;
      chk("readc_spacing", 288'(gaps), 288'(0));
    end

    chk("res_count", 288'(obs_res.size()), 288'(16));
    nres = (obs_res.size() < 16) ? obs_res.size() : 16;
    for (int i = 0; i < nres; i++) begin
      er[132:129] = 4'(i / 2);
      er[128]     = 1'(i % 2);
      for (int k = 0; k < 4; k++) er[k*32 +: 32] = tpu_word(salt, 4'(i / 2), 1'(i % 2), k);
      chk($sformatf("res%0d", i), 288'(obs_res[i]), 288'(er));
    end
  endtask

  initial begin
    logic [127:0] rd0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_clr = 1'b0; op_valid = 1'b0;
    op_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) rd0[k*32 +: 32] = res_data[k];
    chk("rst_opcode", 288'(opcode), 288'(7));
    chk("rst_idx", 288'(idx), 288'(0));
    chk("rst_cmd_ready", 288'(cmd_ready), 288'(1));
    chk("rst_op_ready", 288'(op_ready), 288'(0));
    chk("rst_res_valid", 288'(res_valid), 288'(0));
    chk("rst_done", 288'(done), 288'(0));
    chk("rst_res_data", 288'(rd0), 288'(0));
    rst = 1'b0;

    run_cmd(1'b0, 0, 0, 0, 0);   // directed rows, back-to-back, no clear
    run_cmd(1'b1, 1, 1, 2, 0);   // toggling op_valid, clear C, stalled result consumer
    run_cmd(1'b1, 1, 0, 0, 5);   // reset during the fifth matmul
    run_cmd(1'b1, 1, 2, 1, 0);   // full command after the abort
    for (int t = 0; t < 3; t++)
      run_cmd(1'($urandom % 2), 1, 2, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
